// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction handshake plus datapath control/result bundle
// between the MCU decode stage, the ALU/REGBANK datapath and alu_sequencer.
//   master : decode/datapath side (drives INSTR_*, HOLD, ANSWER)
//   slave  : the sequencer (drives INSTR_READY, operand/control lines, RESULT,
//            DONE, ERR, CC)
interface alu_sequencer_if;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [1:0]  INSTR_OP;
  logic [1:0]  INSTR_SRC;
  logic [2:0]  INSTR_SR1;
  logic [2:0]  INSTR_SR2;
  logic [2:0]  INSTR_DR;
  logic [7:0]  INSTR_DATA;
  logic [6:0]  INSTR_ADDR;
  logic        HOLD;
  logic [15:0] ANSWER;
  logic [1:0]  ALUK;
  logic [1:0]  SR2SELECT;
  logic [2:0]  REGISTER1;
  logic [2:0]  REGISTER2;
  logic [2:0]  DR;
  logic [7:0]  DATA;
  logic [6:0]  ADDRESS;
  logic        GATEALU;
  logic        LDREGF;
  logic [15:0] RESULT;
  logic        DONE;
  logic        ERR;
  logic [2:0]  CC;

  modport master (
    output INSTR_VALID, INSTR_OP, INSTR_SRC, INSTR_SR1, INSTR_SR2, INSTR_DR,
           INSTR_DATA, INSTR_ADDR, HOLD, ANSWER,
    input  INSTR_READY, ALUK, SR2SELECT, REGISTER1, REGISTER2, DR, DATA,
           ADDRESS, GATEALU, LDREGF, RESULT, DONE, ERR, CC
  );

  modport slave (
    input  INSTR_VALID, INSTR_OP, INSTR_SRC, INSTR_SR1, INSTR_SR2, INSTR_DR,
           INSTR_DATA, INSTR_ADDR, HOLD, ANSWER,
    output INSTR_READY, ALUK, SR2SELECT, REGISTER1, REGISTER2, DR, DATA,
           ADDRESS, GATEALU, LDREGF, RESULT, DONE, ERR, CC
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller for one ALU instruction at a time.
// Sequence: IDLE (accept) -> READ (regbank settles) -> EXEC (GATEALU, held by
// HOLD) -> WB (LDREGF + DONE, RESULT captured) -> IDLE. An illegal operand-2
// select (INSTR_SRC=11) goes IDLE -> FAULT (ERR pulse) -> IDLE.
// Ports:
//   CLK    clock, rising edge
//   RESET  synchronous active-high reset
//   bus    alu_sequencer_if.slave: instruction handshake, HOLD/ANSWER from the
//          ALU, latched control/operand lines, RESULT, DONE, ERR, CC
// Optional feature: define ALU_SEQ_CC_EN to get N/Z/P condition codes updated
// on write-back; without it CC is tied to 3'b000.
module alu_sequencer (
  input logic            CLK,
  input logic            RESET,
  alu_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, FAULT} state_t;

  typedef struct packed {
    logic [1:0] aluk;
    logic [1:0] sel;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [2:0] dr;
    logic [7:0] data;
    logic [6:0] addr;
  } opnd_t;

  state_t      state;
  opnd_t       opnd_q;
  logic        gate_q, ld_q, done_q, err_q;
  logic [15:0] result_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      opnd_q   <= '0;
      gate_q   <= 1'b0;
      ld_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      // strobes are single-cycle unless re-armed below
      ld_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: if (bus.INSTR_VALID) begin
          // operand lines are latched even for an illegal select
          opnd_q <= '{aluk: bus.INSTR_OP,  sel: bus.INSTR_SRC,
                      r1:   bus.INSTR_SR1, r2:  bus.INSTR_SR2,
                      dr:   bus.INSTR_DR,  data: bus.INSTR_DATA,
                      addr: bus.INSTR_ADDR};
          if (bus.INSTR_SRC == 2'b11) begin
            err_q <= 1'b1;
            state <= FAULT;
          end else begin
            state <= READ;
          end
        end
        READ: begin
          gate_q <= 1'b1;
          state  <= EXEC;
        end
        EXEC: if (!bus.HOLD) begin
          result_q <= bus.ANSWER;
          gate_q   <= 1'b0;
          ld_q     <= 1'b1;
          done_q   <= 1'b1;
          state    <= WB;
        end
        WB:      state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_CC_EN
  logic [2:0] cc_q;
  // flags load on the same edge as RESULT so they are valid during WB
  always_ff @(posedge CLK) begin
    if (RESET)
      cc_q <= 3'b010;
    else if (state == EXEC && !bus.HOLD)
      cc_q <= bus.ANSWER[15]        ? 3'b100 :
              (bus.ANSWER == 16'h0) ? 3'b010 : 3'b001;
  end
  assign bus.CC = cc_q;
`else
  assign bus.CC = 3'b000;
`endif

  assign bus.INSTR_READY = (state == IDLE) && !RESET;
  assign bus.ALUK        = opnd_q.aluk;
  assign bus.SR2SELECT   = opnd_q.sel;
  assign bus.REGISTER1   = opnd_q.r1;
  assign bus.REGISTER2   = opnd_q.r2;
  assign bus.DR          = opnd_q.dr;
  assign bus.DATA        = opnd_q.data;
  assign bus.ADDRESS     = opnd_q.addr;
  assign bus.GATEALU     = gate_q;
  assign bus.LDREGF      = ld_q;
  assign bus.DONE        = done_q;
  assign bus.ERR         = err_q;
  assign bus.RESULT      = result_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed + randomized stimulus for alu_sequencer. The
// issuing process pushes the expected completion (kind, cycle, result, flags,
// latched fields) into a queue; a separate monitor pops and compares whenever
// DONE/ERR/LDREGF is seen.
module tb_alu_sequencer;
  logic CLK = 1'b0;
  logic RESET;
  alu_sequencer_if bus ();
  alu_sequencer dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    int          cyc;
    logic [15:0] result;
    logic [2:0]  cc;
    logic [1:0]  op, src;
    logic [2:0]  sr1, sr2, dr;
    logic [7:0]  d;
    logic [6:0]  a;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_result;
  logic [2:0]  m_cc;

`ifdef ALU_SEQ_CC_EN
  localparam logic [2:0] CC_RST = 3'b010;
`else
  localparam logic [2:0] CC_RST = 3'b000;
`endif

  function automatic logic [2:0] flags(input logic [15:0] v);
`ifdef ALU_SEQ_CC_EN
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0)     return 3'b010;
    return 3'b001;
`else
    return 3'b000;
`endif
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: every completion or write strobe must match the head of the queue
  exp_t m;
  always @(negedge CLK) begin
    if (RESET !== 1'b1 && (bus.DONE === 1'b1 || bus.ERR === 1'b1 || bus.LDREGF === 1'b1)) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: DONE=%b ERR=%b LDREGF=%b with nothing pending (cycle %0d)",
                 bus.DONE, bus.ERR, bus.LDREGF, cyc);
      end else begin
        m = q.pop_front();
        check("kind {DONE,ERR,LDREGF}", {61'd0, bus.DONE, bus.ERR, bus.LDREGF},
              m.err ? 64'b010 : 64'b101);
        check("cycle", 64'(cyc), 64'(m.cyc));
        check("RESULT", 64'(bus.RESULT), 64'(m.result));
        check("CC", 64'(bus.CC), 64'(m.cc));
        check("GATEALU_off", 64'(bus.GATEALU), 64'd0);
        check("operand_lines",
              64'({bus.ALUK, bus.SR2SELECT, bus.REGISTER1, bus.REGISTER2, bus.DR, bus.DATA, bus.ADDRESS}),
              64'({m.op, m.src, m.sr1, m.sr2, m.dr, m.d, m.a}));
      end
    end
  end

  // called at a negedge with the DUT idle; returns at a negedge with it idle again
  task automatic issue(input logic [1:0] op, input logic [1:0] src, input logic [2:0] sr1,
                       input logic [2:0] sr2, input logic [2:0] dr, input logic [7:0] d,
                       input logic [6:0] a, input int h, input logic [15:0] ans);
    exp_t e;
    int   n = 0;
    bus.INSTR_OP = op;  bus.INSTR_SRC = src; bus.INSTR_SR1 = sr1; bus.INSTR_SR2 = sr2;
    bus.INSTR_DR = dr;  bus.INSTR_DATA = d;  bus.INSTR_ADDR = a;  bus.INSTR_VALID = 1'b1;
    while (bus.INSTR_READY !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    check("accept_within_bound", 64'(n < 50), 64'd1);
    if (n >= 50) begin bus.INSTR_VALID = 1'b0; return; end
    // accept edge starts cycle cyc+1: ERR there, DONE two cycles plus holds later
    e.err = (src == 2'b11);
    e.cyc = e.err ? cyc + 1 : cyc + 3 + h;
    if (!e.err) begin m_result = ans; m_cc = flags(ans); end
    e.result = m_result; e.cc = m_cc;
    e.op = op; e.src = src; e.sr1 = sr1; e.sr2 = sr2; e.dr = dr; e.d = d; e.a = a;
    q.push_back(e);
    @(negedge CLK);
    bus.INSTR_VALID = 1'b0;
    if (e.err) begin
      check("no_gate_in_fault", 64'(bus.GATEALU), 64'd0);
      @(negedge CLK);
      check("ready_after_fault", 64'(bus.INSTR_READY), 64'd1);
      return;
    end
    bus.HOLD   = (h > 0);
    bus.ANSWER = (h > 0) ? 16'($urandom) : ans;
    @(negedge CLK);
    check("GATEALU_in_exec", 64'(bus.GATEALU), 64'd1);
    repeat (h) @(negedge CLK);
    bus.HOLD   = 1'b0;
    bus.ANSWER = ans;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  exp_t b;
  initial begin
    int n;
    RESET = 1'b1;
    bus.INSTR_VALID = 1'b1; bus.INSTR_OP = 2'b11; bus.INSTR_SRC = 2'b01;
    bus.INSTR_SR1 = 3'd7; bus.INSTR_SR2 = 3'd6; bus.INSTR_DR = 3'd5;
    bus.INSTR_DATA = 8'hA5; bus.INSTR_ADDR = 7'h33; bus.HOLD = 1'b0; bus.ANSWER = 16'hFFFF;
    m_result = '0; m_cc = CC_RST;

    // reset with VALID asserted: nothing may be accepted
    @(negedge CLK);
    check("ready_in_reset", 64'(bus.INSTR_READY), 64'd0);
    @(negedge CLK);
    check("ready_in_reset2", 64'(bus.INSTR_READY), 64'd0);
    bus.INSTR_VALID = 1'b0;
    RESET = 1'b0;
    @(negedge CLK);
    check("ready_after_reset", 64'(bus.INSTR_READY), 64'd1);
    check("outputs_after_reset",
          64'({bus.ALUK, bus.SR2SELECT, bus.REGISTER1, bus.REGISTER2, bus.DR, bus.DATA,
               bus.ADDRESS, bus.GATEALU, bus.LDREGF, bus.RESULT, bus.DONE, bus.ERR}), 64'd0);
    check("CC_after_reset", 64'(bus.CC), 64'(CC_RST));

    issue(2'b11, 2'b00, 3'd1, 3'd2, 3'd3, 8'h00, 7'h00, 0, 16'h0005);  // register ADD
    issue(2'b11, 2'b01, 3'd0, 3'd0, 3'd4, 8'hFF, 7'h00, 2, 16'h8000);  // DATA, 2 holds
    issue(2'b10, 2'b11, 3'd2, 3'd3, 3'd1, 8'h12, 7'h7F, 0, 16'h0000);  // illegal select
    issue(2'b00, 2'b10, 3'd5, 3'd6, 3'd7, 8'h01, 7'h40, 1, 16'h7FFF);  // ADDRESS, 1 hold

    // reset while GATEALU is up: the instruction is dropped without strobes
    bus.INSTR_OP = 2'b11; bus.INSTR_SRC = 2'b00; bus.INSTR_SR1 = 3'd3; bus.INSTR_SR2 = 3'd4;
    bus.INSTR_DR = 3'd2; bus.INSTR_DATA = 8'h11; bus.INSTR_ADDR = 7'h22;
    bus.HOLD = 1'b1; bus.INSTR_VALID = 1'b1;
    @(negedge CLK);
    bus.INSTR_VALID = 1'b0;
    n = 0;
    while (bus.GATEALU !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    check("gate_seen_before_reset", 64'(n < 20), 64'd1);
    RESET = 1'b1;
    q.delete();
    @(negedge CLK);
    check("no_strobe_in_reset", 64'({bus.LDREGF, bus.DONE, bus.ERR}), 64'd0);
    @(negedge CLK);
    RESET = 1'b0; bus.HOLD = 1'b0;
    m_result = '0; m_cc = CC_RST;
    @(negedge CLK);
    check("outputs_after_mid_reset",
          64'({bus.ALUK, bus.SR2SELECT, bus.REGISTER1, bus.REGISTER2, bus.DR, bus.DATA,
               bus.ADDRESS, bus.GATEALU, bus.LDREGF, bus.RESULT, bus.DONE, bus.ERR}), 64'd0);
    check("CC_after_mid_reset", 64'(bus.CC), 64'(CC_RST));
    check("ready_after_mid_reset", 64'(bus.INSTR_READY), 64'd1);
    repeat (4) @(negedge CLK);  // monitor flags any late DONE

    // back-to-back with VALID held: second accept lands exactly four cycles later
    bus.INSTR_OP = 2'b11; bus.INSTR_SRC = 2'b00; bus.INSTR_SR1 = 3'd1; bus.INSTR_SR2 = 3'd1;
    bus.INSTR_DR = 3'd6; bus.INSTR_DATA = 8'h00; bus.INSTR_ADDR = 7'h00;
    bus.HOLD = 1'b0; bus.ANSWER = 16'h1234; bus.INSTR_VALID = 1'b1;
    check("b2b_ready_first", 64'(bus.INSTR_READY), 64'd1);
    b = '{err: 1'b0, cyc: cyc + 3, result: 16'h1234, cc: flags(16'h1234), op: 2'b11,
          src: 2'b00, sr1: 3'd1, sr2: 3'd1, dr: 3'd6, d: 8'h00, a: 7'h00};
    q.push_back(b); m_result = 16'h1234; m_cc = flags(16'h1234);
    @(negedge CLK);
    bus.INSTR_OP = 2'b01; bus.INSTR_SRC = 2'b10; bus.INSTR_SR1 = 3'd4; bus.INSTR_SR2 = 3'd5;
    bus.INSTR_DR = 3'd7; bus.INSTR_DATA = 8'h3C; bus.INSTR_ADDR = 7'h55;
    repeat (3) begin
      check("b2b_not_ready", 64'(bus.INSTR_READY), 64'd0);
      @(negedge CLK);
    end
    check("b2b_ready_at_t4", 64'(bus.INSTR_READY), 64'd1);
    b = '{err: 1'b0, cyc: cyc + 3, result: 16'h0000, cc: flags(16'h0000), op: 2'b01,
          src: 2'b10, sr1: 3'd4, sr2: 3'd5, dr: 3'd7, d: 8'h3C, a: 7'h55};
    q.push_back(b); m_result = 16'h0000; m_cc = flags(16'h0000);
    @(negedge CLK);
    bus.INSTR_VALID = 1'b0; bus.ANSWER = 16'h0000;
    repeat (3) @(negedge CLK);

    // randomized instructions
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  src;
      logic [15:0] ans;
      int          r;
      src = ($urandom_range(7) == 0) ? 2'b11 : 2'($urandom_range(2));
      r   = $urandom_range(5);
      ans = (r == 0) ? 16'h0000 : (r == 1) ? 16'h8000 : 16'($urandom);
      issue(2'($urandom), src, 3'($urandom), 3'($urandom), 3'($urandom),
            8'($urandom), 7'($urandom), $urandom_range(3), ans);
    end

    n = 0;
    while (q.size() != 0 && n < 20) begin @(negedge CLK); n++; end
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
